// File: rtl/synd_cal_odd_seq_pkg.sv
// Shared definitions for the odd-syndrome BCH calculator: field defaults, FSM
// state encoding and the elaboration-time helpers used to build constant multipliers.
package synd_cal_odd_seq_pkg;

    localparam int          GF_LEN_DEF    = 10;
    localparam logic [10:0] PRIM_POLY_DEF = 11'h409;
    localparam int          GF_MAX        = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // alpha^exp as a polynomial-basis element; poly includes the x^gf_len term
    function automatic logic [GF_MAX-1:0] alpha_pow(input int gf_len,
                                                    input logic [GF_MAX-1:0] poly,
                                                    input int exp);
        logic [GF_MAX-1:0] v;
        v = 1;
        for (int i = 0; i < exp; i++) begin
            v = v << 1;
            if (v[gf_len]) v = v ^ poly;
        end
        return v;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (((value - 1) >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/synd_cal_odd_seq_gf_mult.sv
// Combinational multiply of a field element by the constant alpha^EXP.
// Each input bit i selects the column alpha^(i+EXP); the product is their XOR.
module gf_const_mult
    import synd_cal_odd_seq_pkg::*;
#(
    parameter int               GF_LEN    = GF_LEN_DEF,
    parameter logic [GF_LEN:0]  PRIM_POLY = (GF_LEN+1)'(PRIM_POLY_DEF),
    parameter int               EXP       = 1
) (
    input  logic [GF_LEN-1:0] x,
    output logic [GF_LEN-1:0] y
);

    logic [GF_LEN-1:0] col [GF_LEN];

    for (genvar i = 0; i < GF_LEN; i++) begin : g_col
        localparam logic [GF_MAX-1:0] COL_VAL =
            alpha_pow(GF_LEN, GF_MAX'(PRIM_POLY), i + EXP);
        assign col[i] = COL_VAL[GF_LEN-1:0];
    end

    always_comb begin
        y = '0;
        for (int i = 0; i < GF_LEN; i++) begin
            if (x[i]) y = y ^ col[i];
        end
    end

endmodule

// File: rtl/synd_cal_odd_seq.sv
// Bit-serial odd-syndrome calculator (S1, S3, ... S(2T-1)) with start/enable framing.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | after reset; waits for start, enables ignored
//   ST_ACCUM | Horner accumulation, one accepted bit per enabled cycle
//   ST_DONE  | N_BITS bits taken; syndromes frozen and valid until next start
module synd_cal_odd_seq
    import synd_cal_odd_seq_pkg::*;
#(
    parameter int               GF_LEN    = GF_LEN_DEF,
    parameter logic [GF_LEN:0]  PRIM_POLY = (GF_LEN+1)'(PRIM_POLY_DEF),
    parameter int               T_CORR    = 3,
    parameter int               N_BITS    = 1023
) (
    input  logic                     clk,
    input  logic                     in_ctr_Arst_n,
    input  logic                     in_ctr_start,
    input  logic                     in_ctr_en,
    input  logic                     in_data,
    output logic                     out_ctr_busy,
    output logic                     out_ctr_done,
    output logic                     out_ctr_valid,
    output logic                     out_ctr_zero,
    output logic [T_CORR*GF_LEN-1:0] out_synd_TP
);

    localparam int              CNT_W    = clog2(N_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [GF_LEN-1:0]  synd [T_CORR];
    logic [GF_LEN-1:0]  prod [T_CORR];
    logic [GF_LEN-1:0]  first_bit;

    assign first_bit = {{(GF_LEN-1){1'b0}}, in_data};

    for (genvar k = 0; k < T_CORR; k++) begin : g_synd
        gf_const_mult #(
            .GF_LEN    (GF_LEN),
            .PRIM_POLY (PRIM_POLY),
            .EXP       (2*k + 1)
        ) u_mult (
            .x (synd[k]),
            .y (prod[k])
        );
        assign out_synd_TP[k*GF_LEN +: GF_LEN] = synd[k];
    end

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            out_ctr_busy  <= 1'b0;
            out_ctr_done  <= 1'b0;
            out_ctr_valid <= 1'b0;
            for (int k = 0; k < T_CORR; k++) synd[k] <= '0;
        end else begin
            out_ctr_done <= 1'b0;
            // start wins in every state, so a running frame is silently abandoned
            if (in_ctr_start) begin
                state         <= ST_ACCUM;
                out_ctr_busy  <= 1'b1;
                out_ctr_valid <= 1'b0;
                cnt           <= in_ctr_en ? CNT_W'(1) : '0;
                for (int k = 0; k < T_CORR; k++)
                    synd[k] <= in_ctr_en ? first_bit : '0;
            end else begin
                case (state)
                    ST_ACCUM: begin
                        if (in_ctr_en) begin
                            cnt <= cnt + CNT_W'(1);
                            for (int k = 0; k < T_CORR; k++)
                                synd[k] <= prod[k] ^ first_bit;
                            if (cnt == CNT_LAST) begin
                                state         <= ST_DONE;
                                out_ctr_busy  <= 1'b0;
                                out_ctr_done  <= 1'b1;
                                out_ctr_valid <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_ctr_zero = out_ctr_valid & ~(|out_synd_TP);

endmodule

// File: tb/tb_synd_cal_odd_seq.sv
// Directed bench for synd_cal_odd_seq: default GF(2^10)/T=3/N=1023 instance plus a
// small GF(2^4)/T=8/N=15 instance.
module tb_synd_cal_odd_seq;

    localparam int GL = 10, T = 3, N = 1023;
    localparam int GL2 = 4, T2 = 8, N2 = 15;

    logic clk = 1'b0;
    logic rst_n, start, en, data;
    logic busy, done, valid, zero;
    logic [T*GL-1:0] synd;

    logic s_start, s_en, s_data;
    logic s_busy, s_done, s_valid, s_zero;
    logic [T2*GL2-1:0] s_synd;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit busy_bad;

    logic        cw  [N];
    logic        cw2 [N2];
    logic [31:0] exp_s  [T];
    logic [31:0] exp_s2 [T2];

    always #5 clk = ~clk;

    synd_cal_odd_seq #(.GF_LEN(GL), .PRIM_POLY(11'h409), .T_CORR(T), .N_BITS(N)) dut (
        .clk(clk), .in_ctr_Arst_n(rst_n), .in_ctr_start(start), .in_ctr_en(en),
        .in_data(data), .out_ctr_busy(busy), .out_ctr_done(done),
        .out_ctr_valid(valid), .out_ctr_zero(zero), .out_synd_TP(synd));

    synd_cal_odd_seq #(.GF_LEN(GL2), .PRIM_POLY(5'h13), .T_CORR(T2), .N_BITS(N2)) dut_small (
        .clk(clk), .in_ctr_Arst_n(rst_n), .in_ctr_start(s_start), .in_ctr_en(s_en),
        .in_data(s_data), .out_ctr_busy(s_busy), .out_ctr_done(s_done),
        .out_ctr_valid(s_valid), .out_ctr_zero(s_zero), .out_synd_TP(s_synd));

    always @(posedge clk) begin
        #2;
        if (done) done_cnt++;
    end

    function automatic logic [31:0] amul(input logic [31:0] v, input int m,
                                         input logic [31:0] poly, input int e);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < e; i++) begin
            r = r << 1;
            if (r[m]) r = r ^ poly;
        end
        return r;
    endfunction

    task automatic model1();
        for (int k = 0; k < T; k++) begin
            logic [31:0] s;
            s = 0;
            for (int i = 0; i < N; i++) s = amul(s, GL, 32'h409, 2*k+1) ^ {31'b0, cw[i]};
            exp_s[k] = s;
        end
    endtask

    task automatic model2();
        for (int k = 0; k < T2; k++) begin
            logic [31:0] s;
            s = 0;
            for (int i = 0; i < N2; i++) s = amul(s, GL2, 32'h13, 2*k+1) ^ {31'b0, cw2[i]};
            exp_s2[k] = s;
        end
    endtask

    task automatic rand_cw();
        for (int i = 0; i < N; i++) cw[i] = 1'($urandom_range(1));
    endtask

    // presents the whole codeword; returns with the last bit on the inputs
    task automatic send_frame(input int gap_pct, input bit with_bit, input bit no_wait);
        int i;
        if (!no_wait) @(negedge clk);
        start = 1'b1;
        en    = with_bit;
        data  = with_bit ? cw[0] : 1'b0;
        i     = with_bit ? 1 : 0;
        busy_bad = 1'b0;
        while (i < N) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad = 1'b1;
            start = 1'b0;
            if (int'($urandom_range(99)) < gap_pct) begin
                en   = 1'b0;
                data = 1'($urandom_range(1));
            end else begin
                en   = 1'b1;
                data = cw[i];
                i++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; en = 0; data = 0;
        s_start = 0; s_en = 0; s_data = 0;
        #12;
        checks++;
        if ({busy, done, valid, zero} !== 4'b0000 || synd !== '0) begin
            errors++;
            $display("FAIL reset: busy/done/valid/zero=%b synd=%h required 0000/0", {busy, done, valid, zero}, synd);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin @(negedge clk); en = 1'b1; data = 1'b1; end
        @(negedge clk); en = 1'b0;
        checks++;
        if (busy !== 1'b0 || synd !== '0) begin
            errors++;
            $display("FAIL idle_en_ignored: busy=%b synd=%h required 0/0", busy, synd);
        end
    endtask

    task automatic test_all_zero();
        int snap;
        for (int i = 0; i < N; i++) cw[i] = 1'b0;
        snap = done_cnt;
        send_frame(0, 1'b1, 1'b0);
        @(negedge clk); en = 1'b0;
        checks++;
        if ({done, valid, busy, zero} !== 4'b1101 || synd !== '0) begin
            errors++;
            $display("FAIL all_zero: done/valid/busy/zero=%b synd=%h required 1101/0", {done, valid, busy, zero}, synd);
        end
        @(negedge clk); en = 1'b1; data = 1'b1;
        @(negedge clk); en = 1'b0;
        checks++;
        if (done !== 1'b0 || valid !== 1'b1 || synd !== '0 || done_cnt - snap != 1) begin
            errors++;
            $display("FAIL all_zero_hold: done=%b valid=%b synd=%h pulses=%0d required 0/1/0/1", done, valid, synd, done_cnt - snap);
        end
    endtask

    task automatic test_single_bits();
        int          pos [3];
        logic [9:0]  hand [3][3];
        pos[0] = N-1; hand[0][0] = 10'h001; hand[0][1] = 10'h001; hand[0][2] = 10'h001;
        pos[1] = 0;   hand[1][0] = 10'h204; hand[1][1] = 10'h081; hand[1][2] = 10'h122;
        pos[2] = N-2; hand[2][0] = 10'h002; hand[2][1] = 10'h008; hand[2][2] = 10'h020;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) cw[i] = (i == pos[c]);
            send_frame(10, c[0], 1'b0);
            @(negedge clk); en = 1'b0;
            checks++;
            if ({done, valid, zero} !== 3'b110) begin
                errors++;
                $display("FAIL single_%0d_flags: done/valid/zero=%b required 110", c, {done, valid, zero});
            end
            for (int k = 0; k < T; k++) begin
                checks++;
                if (synd[k*GL +: GL] !== hand[c][k]) begin
                    errors++;
                    $display("FAIL single_%0d S%0d: got %h expected %h", c, 2*k+1, synd[k*GL +: GL], hand[c][k]);
                end
            end
        end
    endtask

    task automatic test_random_gaps();
        for (int f = 0; f < 2; f++) begin
            rand_cw();
            model1();
            send_frame(30, f[0], 1'b0);
            @(negedge clk); en = 1'b0;
            checks++;
            if (busy_bad || done !== 1'b1 || valid !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d_flags: busy_drop=%b done=%b valid=%b required 0/1/1", f, busy_bad, done, valid);
            end
            for (int k = 0; k < T; k++) begin
                checks++;
                if (synd[k*GL +: GL] !== exp_s[k][GL-1:0]) begin
                    errors++;
                    $display("FAIL random_%0d S%0d: got %h expected %h", f, 2*k+1, synd[k*GL +: GL], exp_s[k][GL-1:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rand_cw();
        send_frame(0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b required 1", done);
        end
        rand_cw();
        model1();
        send_frame(0, 1'b1, 1'b1);
        @(negedge clk); start = 1'b0; en = 1'b0;
        checks++;
        if (done !== 1'b1 || busy_bad) begin
            errors++;
            $display("FAIL b2b_second_done: done=%b busy_drop=%b required 1/0", done, busy_bad);
        end
        for (int k = 0; k < T; k++) begin
            checks++;
            if (synd[k*GL +: GL] !== exp_s[k][GL-1:0]) begin
                errors++;
                $display("FAIL b2b S%0d: got %h expected %h", 2*k+1, synd[k*GL +: GL], exp_s[k][GL-1:0]);
            end
        end
    endtask

    task automatic test_abort();
        int snap;
        rand_cw();
        snap = done_cnt;
        @(negedge clk); start = 1'b1; en = 1'b1; data = cw[0];
        for (int i = 1; i < 500; i++) begin
            @(negedge clk); start = 1'b0; en = 1'b1; data = cw[i];
        end
        rand_cw();
        model1();
        send_frame(20, 1'b1, 1'b0);
        @(negedge clk); en = 1'b0;
        checks++;
        if (done !== 1'b1 || done_cnt - snap != 1) begin
            errors++;
            $display("FAIL abort_pulses: done=%b pulses=%0d required 1/1", done, done_cnt - snap);
        end
        for (int k = 0; k < T; k++) begin
            checks++;
            if (synd[k*GL +: GL] !== exp_s[k][GL-1:0]) begin
                errors++;
                $display("FAIL abort S%0d: got %h expected %h", 2*k+1, synd[k*GL +: GL], exp_s[k][GL-1:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < N; i++) cw[i] = 1'b1;
        @(negedge clk); start = 1'b1; en = 1'b1; data = 1'b1;
        repeat (300) begin @(negedge clk); start = 1'b0; end
        @(negedge clk); rst_n = 1'b0; en = 1'b0;
        #1;
        checks++;
        if ({busy, done, valid, zero} !== 4'b0000 || synd !== '0) begin
            errors++;
            $display("FAIL rst_mid: busy/done/valid/zero=%b synd=%h required 0000/0", {busy, done, valid, zero}, synd);
        end
        #2 rst_n = 1'b1;
        repeat (4) begin @(negedge clk); en = 1'b1; data = 1'b1; end
        @(negedge clk); en = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || synd !== '0) begin
            errors++;
            $display("FAIL rst_mid_idle: busy=%b valid=%b synd=%h required 0/0/0", busy, valid, synd);
        end
        send_frame(0, 1'b1, 1'b0);
        @(negedge clk); en = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, valid, zero} !== 4'b0000 || synd !== '0) begin
            errors++;
            $display("FAIL rst_done: busy/done/valid/zero=%b synd=%h required 0000/0", {busy, done, valid, zero}, synd);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_small_field();
        for (int f = 0; f < 2; f++) begin
            int i;
            for (int j = 0; j < N2; j++) cw2[j] = (f == 0) ? (j == 0) : 1'($urandom_range(1));
            model2();
            @(negedge clk); s_start = 1'b1; s_en = 1'b0; i = 0;
            while (i < N2) begin
                @(negedge clk); s_start = 1'b0;
                if (f == 1 && $urandom_range(3) == 0) s_en = 1'b0;
                else begin s_en = 1'b1; s_data = cw2[i]; i++; end
            end
            @(negedge clk); s_en = 1'b0;
            checks++;
            if (s_done !== 1'b1 || s_valid !== 1'b1) begin
                errors++;
                $display("FAIL small_%0d_flags: done=%b valid=%b required 1/1", f, s_done, s_valid);
            end
            if (f == 0) begin
                checks++;
                if (s_synd[3:0] !== 4'h9 || s_synd[7:4] !== 4'hF) begin
                    errors++;
                    $display("FAIL small_hand: S1=%h S3=%h required 9/f", s_synd[3:0], s_synd[7:4]);
                end
            end
            for (int k = 0; k < T2; k++) begin
                checks++;
                if (s_synd[k*GL2 +: GL2] !== exp_s2[k][GL2-1:0]) begin
                    errors++;
                    $display("FAIL small_%0d S%0d: got %h expected %h", f, 2*k+1, s_synd[k*GL2 +: GL2], exp_s2[k][GL2-1:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_single_bits();
        test_random_gaps();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_small_field();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
